// File: rtl/lite16_ctrl_seq.sv
// lite16_ctrl_seq: multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer for the
// LITE-16 core, with run/stop/halt control, a memory-ack timeout and a
// retired-instruction counter.
module lite16_ctrl_seq #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [15:0]      instruction,
    input  logic             mem_ack,
    output logic             ir_load,
    output logic             pc_en,
    output logic             pc_jmp,
    output logic             alu_en,
    output logic             mem_req,
    output logic             mem_we,
    output logic             reg_we,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instr_count
);

    localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

    localparam logic [3:0] OP_HALT = 4'hF;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_LD   = 4'hD;
    localparam logic [3:0] OP_ST   = 4'hC;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       opcode_q, opcode_d;
    logic [TO_W-1:0]  to_q, to_d, to_inc;
    logic             fault_q, fault_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic ir_load_q, ir_load_d;
    logic pc_en_q,   pc_en_d;
    logic pc_jmp_q,  pc_jmp_d;
    logic alu_en_q,  alu_en_d;
    logic mem_req_q, mem_req_d;
    logic mem_we_q,  mem_we_d;
    logic reg_we_q,  reg_we_d;
    logic halted_q,  halted_d;

    // A store retires in its acknowledging MEM cycle, so that one pc_en source is mem_ack-qualified
    logic st_ack;

    // Only the opcode field is decoded here; the rest of the word belongs to the datapath
    logic unused_instr_bits;
    assign unused_instr_bits = ^instruction[11:0];

    // Next-state, opcode latch, memory timeout counter and sticky fault
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        to_d     = to_q;
        fault_d  = fault_q;
        st_ack   = 1'b0;
        to_inc   = to_q + 1'b1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                opcode_d = instruction[15:12];
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                to_d = '0;
                case (opcode_q)
                    OP_HALT:      state_d = S_HALT;
                    OP_LD, OP_ST: state_d = S_MEM;
                    default:      state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (opcode_q == OP_JMP) begin
                    state_d = stop ? S_IDLE : S_FETCH;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                // An ack in the same cycle the timeout would expire still completes normally
                if (mem_ack) begin
                    if (opcode_q == OP_ST) begin
                        st_ack  = 1'b1;
                        state_d = stop ? S_IDLE : S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    to_d = to_inc;
                    if (to_inc == TO_W'(MEM_TIMEOUT)) begin
                        state_d = S_HALT;
                        fault_d = 1'b1;
                    end
                end
            end
            S_WB: begin
                state_d = stop ? S_IDLE : S_FETCH;
            end
            S_HALT: begin
                if (start) begin
                    fault_d = 1'b0;
                    state_d = S_FETCH;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore outputs decoded from the state and opcode being entered, so the flops present them in that state
    always_comb begin
        ir_load_d = (state_d == S_FETCH);
        pc_jmp_d  = (state_d == S_EXEC) && (opcode_d == OP_JMP);
        alu_en_d  = (state_d == S_EXEC) && (opcode_d != OP_JMP);
        reg_we_d  = (state_d == S_WB);
        pc_en_d   = (state_d == S_WB) || pc_jmp_d;
        mem_req_d = (state_d == S_MEM);
        mem_we_d  = (state_d == S_MEM) && (opcode_d == OP_ST);
        halted_d  = (state_d == S_HALT);
    end

    assign pc_en = pc_en_q | st_ack;

    // Retired-instruction counter steps on every pc_en pulse and wraps naturally
    always_comb begin
        count_d = count_q + CNT_W'(pc_en);
    end

    // State, latched opcode, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            to_q      <= '0;
            fault_q   <= 1'b0;
            count_q   <= '0;
            ir_load_q <= 1'b0;
            pc_en_q   <= 1'b0;
            pc_jmp_q  <= 1'b0;
            alu_en_q  <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            reg_we_q  <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            to_q      <= to_d;
            fault_q   <= fault_d;
            count_q   <= count_d;
            ir_load_q <= ir_load_d;
            pc_en_q   <= pc_en_d;
            pc_jmp_q  <= pc_jmp_d;
            alu_en_q  <= alu_en_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            reg_we_q  <= reg_we_d;
            halted_q  <= halted_d;
        end
    end

    assign ir_load     = ir_load_q;
    assign pc_jmp      = pc_jmp_q;
    assign alu_en      = alu_en_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign reg_we      = reg_we_q;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign instr_count = count_q;

endmodule

// File: doc/lite16_ctrl_seq.md
Name: lite16_ctrl_seq

Overview:
- Multi-cycle control sequencer for the LITE-16 core.
- Drives the program counter register enable, jump select, instruction-register load, memory request and register-file write.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB, so the PC advances exactly once per retired instruction.
- Sits between the PC/program-ROM datapath and the register file/ALU; also provides run/stop/halt control and a retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, max cycles MEM waits for mem_ack before faulting (>=1).
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  level; leaves IDLE or HALT, begins fetching.
- stop  in  1  level; finish the current instruction, then park in IDLE.
- instruction  in  16  ROM output at current PC; opcode = [15:12].
- mem_ack  in  1  data-memory completion, single-cycle pulse.
- ir_load  out  1  load instruction register this cycle.
- pc_en  out  1  PC register write enable (one cycle per instruction).
- pc_jmp  out  1  selects PC+rd instead of PC+1; only with pc_en.
- alu_en  out  1  ALU operation strobe.
- mem_req  out  1  data-memory request, held until mem_ack.
- mem_we  out  1  qualifies mem_req as a store.
- reg_we  out  1  register-file write enable.
- halted  out  1  in HALT state.
- fault  out  1  memory timeout occurred; sticky until start.
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; instr_count=0; latched opcode=0; timeout counter=0.
- Outputs are Moore, decoded from state plus latched opcode. The opcode is latched in FETCH from instruction[15:12].
- Opcode classes: F=HALT, E=JMP, D=LD, C=ST, all others ALU.
- IDLE: all strobes 0. start=1 -> FETCH next cycle.
- FETCH: ir_load=1, latch opcode -> DECODE.
- DECODE: HALT -> HALT; JMP or ALU -> EXEC; LD or ST -> MEM. Clear the timeout counter.
- EXEC, ALU: alu_en=1 -> WB.
- EXEC, JMP: pc_en=1, pc_jmp=1 (datapath applies the cmp condition) -> retire.
- MEM: mem_req=1; mem_we=1 for ST. Each cycle without mem_ack increments the timeout counter.
  - mem_ack: LD -> WB; ST -> retire with pc_en=1 in that MEM cycle.
  - Counter reaches MEM_TIMEOUT without ack: -> HALT with fault=1, PC not advanced.
  - mem_ack arriving in the same cycle as the timeout wins: normal completion.
- WB: reg_we=1, pc_en=1 -> retire.
- Retire:
  - instr_count += 1 on the cycle pc_en=1.
  - Next state is IDLE if stop=1 in that cycle, otherwise FETCH.
  - stop is ignored mid-instruction.
- HALT:
  - halted=1; PC not advanced; a HALT instruction does not increment instr_count.
  - start=1 -> clear fault and go to FETCH, re-fetching the same PC.
  - start and stop both high in IDLE/HALT: start wins for one instruction, then stop parks in IDLE.
- Exactly one pc_en pulse per retired instruction; pc_jmp never 1 without pc_en.
- Latency per instruction:
  - ALU: 4 cycles (FETCH, DECODE, EXEC, WB).
  - JMP: 3 cycles.
  - LD: 4 + wait cycles.
  - ST: 3 + wait cycles.
- Reset mid-MEM drops mem_req immediately; no pc_en is issued.

Test Plan:
- Reset, start=1 held, ROM {ALU op 0x1234, ALU op}: pc_en pulses at cycles 4 and 8; reg_we coincides with pc_en; instr_count=2 after cycle 8.
- JMP opcode 0xE005: ir_load at cycle 1, pc_en=pc_jmp=1 at cycle 3; no alu_en, reg_we or mem_req.
- LD 0xD000 with mem_ack after 3 wait cycles: mem_req high 4 cycles; WB reg_we=1, pc_en=1; instr_count +1.
- ST with mem_ack never asserted, MEM_TIMEOUT=16: mem_req high 16 cycles, then halted=1, fault=1, no pc_en. Then start=1 -> fault=0, ir_load next cycle.
- HALT 0xF000: halted=1, instr_count unchanged. Assert stop during an ALU EXEC: WB completes with pc_en, then IDLE, no further ir_load.
- Drive rst=0 asynchronously in MEM: mem_req=0 before the next clock edge; after release, state IDLE, instr_count=0.
